i2c_slave_target: RTL and testbench

// - I2C target (slave) end of the bus: the counterpart to our I2C master FSM. Serves 7-bit-addressed

---
 rtl/i2c_slave_target_pkg.sv | 22 ++
 rtl/i2c_slave_target_if.sv | 29 ++
 rtl/i2c_slave_target_sync_edge.sv | 37 +++
 rtl/i2c_slave_target.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_slave_target.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_target_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, bus-level
// constants and the byte length used by the bit counter.
// No ports (package).
package i2c_slave_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX        = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_e;

    localparam logic       I2C_RW_READ   = 1'b1;
    localparam logic       I2C_ACK       = 1'b0;
    localparam logic       I2C_NACK      = 1'b1;
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_slave_target_if.sv
// Bus and host-side signal bundle for the I2C target.
//   scl_in, sda_in : pad levels seen by the target
//   sda_oe         : 1 = target pulls SDA low
//   ack_en         : host choice to ACK (1) or NACK (0) written data bytes
//   rx_data/rx_valid : received write-data byte and its one-clk strobe
//   tx_data/tx_req : read byte from the host and the one-clk request for it
//   busy, rw       : transfer in progress and its direction (1 = read)
interface i2c_slave_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       ack_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       rw;

    modport slave (
        input  scl_in, sda_in, ack_en, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy, rw
    );

    modport master (
        output scl_in, sda_in, ack_en, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy, rw
    );
endinterface

// File: rtl/i2c_slave_target_sync_edge.sv
// Multi-flop synchroniser for one bus line plus rise/fall detection on the
// synchronised level.
//   clk, reset : system clock, synchronous active-low reset
//   din        : asynchronous pad level
//   level      : synchronised level
//   rise, fall : one-clk strobes on synchronised transitions
// The chain and the history flop reset to 1 (idle bus level) so no edge is
// reported coming out of reset while the bus is idle.
module i2c_slave_target_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target (slave), 7-bit addressing, single/multi-byte write and read,
// no clock stretching. SCL/SDA are oversampled on clk.
//   clk, reset : system clock (>= 8x SCL), synchronous active-low reset
//   bus        : i2c_slave_target_if.slave bundle (pad levels, SDA pull-down
//                enable, host byte interface, busy/rw status)
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | bus free, waiting for START
// ST_ADDR      | shifting in address byte
// ST_ADDR_ACK  | driving ACK for matched address
// ST_RX        | shifting in a write-data byte
// ST_RX_ACK    | driving ACK/NACK for a write-data byte
// ST_TX        | driving a read-data byte, MSB first
// ST_TX_ACK    | SDA released, sampling the master's ACK/NACK
// ST_WAIT_STOP | not addressed or transfer ended; ignore bus until STOP/START
module i2c_slave_target
    import i2c_slave_target_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               reset,
    i2c_slave_target_if.slave bus
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_slave_target_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.scl_in),
        .level (scl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_slave_target_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.sda_in),
        .level (sda),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // Both lines share the same synchroniser depth, so their relative
    // ordering is preserved and SCL level here is the level at the SDA edge.
    logic start_cond, stop_cond;
    assign start_cond = sda_fall & scl;
    assign stop_cond  = sda_rise & scl;

    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;   // ACK decision carried into the next scl_fall

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        sda_oe_d   = sda_oe_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        rw_d       = rw_q;
        ack_d      = ack_q;

        // tx_data is taken in the cycle the request is visible to the host;
        // the first bit is not driven until the following scl_fall.
        if (tx_req_q) begin
            shift_d = bus.tx_data;
        end

        if (stop_cond) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_cond) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == BITS_PER_BYTE - 4'd1) begin
                            if (shift_q[6:0] == SLAVE_ADDR) begin
                                rw_d   = sda;
                                busy_d = 1'b1;
                            end else begin
                                state_d   = ST_WAIT_STOP;
                                bit_cnt_d = 4'd0;
                                busy_d    = 1'b0;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                        state_d   = ST_ADDR_ACK;
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b1;
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_rise && rw_q == I2C_RW_READ) begin
                        tx_req_d = 1'b1;
                    end else if (scl_fall) begin
                        if (rw_q == I2C_RW_READ) begin
                            state_d   = ST_TX;
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d  = ST_RX;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                ST_RX: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == BITS_PER_BYTE - 4'd1) begin
                            rx_data_d  = {shift_q[6:0], sda};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                        state_d   = ST_RX_ACK;
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = bus.ack_en;
                        ack_d     = bus.ack_en;
                    end
                end

                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (ack_q) begin
                            state_d = ST_RX;
                        end else begin
                            state_d = ST_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end

                ST_TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == BITS_PER_BYTE) begin
                            state_d   = ST_TX_ACK;
                            bit_cnt_d = 4'd0;
                            sda_oe_d  = 1'b0;
                        end else begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda == I2C_ACK) begin
                            tx_req_d = 1'b1;
                            ack_d    = 1'b1;
                        end else begin
                            ack_d   = 1'b0;
                            busy_d  = 1'b0;
                            state_d = ST_WAIT_STOP;
                        end
                    end else if (scl_fall && ack_q) begin
                        state_d   = ST_TX;
                        sda_oe_d  = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = 4'd1;
                    end
                end

                default: ;
            endcase
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.busy     = busy_q;
    assign bus.rw       = rw_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Directed bench for i2c_slave_target: bit-banged I2C master on the pads,
// wired-AND SDA, counters of rx_valid / tx_req / sda_oe cycles.
module tb_i2c_slave_target;

    localparam int Q = 5;   // clocks per quarter SCL period

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    always #5 clk = ~clk;

    i2c_slave_target_if bus();

    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_slave_target #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total  = 0;
    int passed = 0;
    int rxv_cnt = 0;
    int txr_cnt = 0;
    int oe_cnt  = 0;

    always @(negedge clk) begin
        if (bus.rx_valid) rxv_cnt++;
        if (bus.tx_req)   txr_cnt++;
        if (bus.sda_oe)   oe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wq();
            scl_m = 1'b1; wq(); wq();
            scl_m = 1'b0; wq();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        ack = bus.sda_oe;
        wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wq();
            scl_m = 1'b1; wq();
            b[i] = bus.sda_in;
            wq();
            scl_m = 1'b0; wq();
        end
        sda_m = mack ? 1'b0 : 1'b1; wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0;
        sda_m = 1'b1; wq();
    endtask

    logic       ack;
    logic [7:0] rd;
    int         rxv0, txr0, oe0;

    initial begin
        bus.ack_en  = 1'b1;
        bus.tx_data = 8'h00;

        // Reset values
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sda_oe",   bus.sda_oe,   1'b0);
        chk("rst_rx_data",  bus.rx_data,  8'h00);
        chk("rst_rx_valid", bus.rx_valid, 1'b0);
        chk("rst_tx_req",   bus.tx_req,   1'b0);
        chk("rst_busy",     bus.busy,     1'b0);
        chk("rst_rw",       bus.rw,       1'b0);
        reset = 1'b1;
        wq();

        // Write 0x3C to 0x50
        rxv0 = rxv_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        chk("wr_addr_ack", ack, 1'b1);
        chk("wr_busy", bus.busy, 1'b1);
        chk("wr_rw", bus.rw, 1'b0);
        write_byte(8'h3C, ack);
        chk("wr_data_ack", ack, 1'b1);
        chk("wr_rx_data", bus.rx_data, 8'h3C);
        chk("wr_rxv_count", rxv_cnt - rxv0, 1);
        i2c_stop();
        chk("wr_busy_after_stop", bus.busy, 1'b0);

        // Read 0xA5, 0x0F with ACK then NACK
        txr0 = txr_cnt;
        bus.tx_data = 8'hA5;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rd_addr_ack", ack, 1'b1);
        chk("rd_rw", bus.rw, 1'b1);
        bus.tx_data = 8'h0F;
        read_byte(1'b1, rd);
        chk("rd_byte0", rd, 8'hA5);
        read_byte(1'b0, rd);
        chk("rd_byte1", rd, 8'h0F);
        chk("rd_txreq_count", txr_cnt - txr0, 2);
        chk("rd_nack_sda_oe", bus.sda_oe, 1'b0);
        chk("rd_nack_busy", bus.busy, 1'b0);
        i2c_stop();

        // Wrong address 0x52
        rxv0 = rxv_cnt;
        oe0  = oe_cnt;
        i2c_start();
        write_byte(8'hA4, ack);
        chk("bad_addr_ack", ack, 1'b0);
        chk("bad_addr_busy", bus.busy, 1'b0);
        write_byte(8'h00, ack);
        chk("bad_data_ack", ack, 1'b0);
        i2c_stop();
        chk("bad_oe_count", oe_cnt - oe0, 0);
        chk("bad_rxv_count", rxv_cnt - rxv0, 0);
        i2c_start();
        write_byte(8'hA0, ack);
        chk("after_bad_ack", ack, 1'b1);
        i2c_stop();

        // Write 0x11, repeated START, read 0x77
        rxv0 = rxv_cnt;
        bus.tx_data = 8'h77;
        i2c_start();
        write_byte(8'hA0, ack);
        chk("rs_rw_write", bus.rw, 1'b0);
        write_byte(8'h11, ack);
        chk("rs_data_ack", ack, 1'b1);
        chk("rs_rx_data", bus.rx_data, 8'h11);
        chk("rs_rxv_count", rxv_cnt - rxv0, 1);
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rs_addr_ack", ack, 1'b1);
        chk("rs_rw_read", bus.rw, 1'b1);
        read_byte(1'b0, rd);
        chk("rs_read_byte", rd, 8'h77);
        i2c_stop();

        // STOP after 4 data bits
        i2c_start();
        write_byte(8'hA0, ack);
        rxv0 = rxv_cnt;
        send_bits(8'hF0, 4);
        i2c_stop();
        chk("part_rxv_count", rxv_cnt - rxv0, 0);
        chk("part_sda_oe", bus.sda_oe, 1'b0);
        chk("part_busy", bus.busy, 1'b0);

        // ack_en = 0: NACK, then ignored until STOP
        bus.ack_en = 1'b0;
        i2c_start();
        write_byte(8'hA0, ack);
        chk("nack_addr_ack", ack, 1'b1);
        write_byte(8'h55, ack);
        chk("nack_data_ack", ack, 1'b0);
        chk("nack_rx_data", bus.rx_data, 8'h55);
        chk("nack_busy", bus.busy, 1'b0);
        rxv0 = rxv_cnt;
        write_byte(8'h66, ack);
        chk("nack_ignored_ack", ack, 1'b0);
        chk("nack_ignored_rxv", rxv_cnt - rxv0, 0);
        chk("nack_ignored_rx_data", bus.rx_data, 8'h55);
        i2c_stop();
        bus.ack_en = 1'b1;

        // Reset mid-read while the target is pulling SDA low (MSB of 0x3C is 0)
        bus.tx_data = 8'h3C;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("mid_sda_oe_driving", bus.sda_oe, 1'b1);
        chk("mid_busy", bus.busy, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_sda_oe",   bus.sda_oe,   1'b0);
        chk("mid_rst_busy",     bus.busy,     1'b0);
        chk("mid_rst_rw",       bus.rw,       1'b0);
        chk("mid_rst_rx_data",  bus.rx_data,  8'h00);
        chk("mid_rst_rx_valid", bus.rx_valid, 1'b0);
        chk("mid_rst_tx_req",   bus.tx_req,   1'b0);
        reset = 1'b1;
        wq();
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, ack);
        chk("post_rst_addr_ack", ack, 1'b1);
        i2c_stop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
